fish_bite_timer: RTL
====================

# fish_bite_timer

Downstream consumer of the 16-bit range-limited LFSR in the fishing game. On each cast it captures the current random value as a bite delay, advances the LFSR, counts the delay down on a time-base tick, and opens a fixed-length bite window. It resolves the reel input as exactly one of caught, missed, or spooked, and the game controller and score logic consume that outcome pulse.

## Interface
- WIDTH, 16, width of `rnd` and of both internal counters
- WINDOW_TICKS, 250, bite-window length in ticks; legal range 1..2^WIDTH-1

- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- cast  in  1  one-cycle pulse, already debounced
- reel  in  1  one-cycle pulse, already debounced
- tick  in  1  one-cycle time-base strobe
- rnd  in  WIDTH  bite delay in ticks, driven by the LFSR `out`
- rnd_run  out  1  one-cycle request driving the LFSR `Run`
- waiting  out  1  high in state WAIT
- bite  out  1  high in state BITE
- caught  out  1  one-cycle outcome pulse
- missed  out  1  one-cycle outcome pulse
- spooked  out  1  one-cycle outcome pulse
- ticks_left  out  WIDTH  active counter value; 0 in IDLE

## Operation
- States:
  - IDLE: `cast` → WAIT; load delay = `rnd`, or 1 if `rnd` == 0.
  - WAIT:
    - `reel` → IDLE with `spooked`.
    - `tick` with counter == 1 → BITE; load window = WINDOW_TICKS.
    - `tick` otherwise → decrement.
  - BITE:
    - `reel` → IDLE with `caught`.
    - `tick` with counter == 1 → IDLE with `missed`.
    - `tick` otherwise → decrement.
- `rnd_run` pulses high for exactly one cycle per accepted cast, so the next cast sees a fresh value.
- `cast` is ignored outside IDLE. `reel` is ignored in IDLE.
- Simultaneous events:
  - `cast` + `reel` in IDLE: cast is accepted.
  - `reel` + final `tick` in WAIT: `spooked`; BITE is not entered.
  - `reel` + final `tick` in BITE: `caught`; reel has priority.
- No wrap-around. A counter never decrements below 1. The zero case is handled only at load.
- Exactly one of `caught`, `missed`, `spooked` fires per cast. None is high in any other cycle.
- RST low mid-operation: immediate return to IDLE, no outcome pulse, no `rnd_run`.

## Timing
- Reset values: state IDLE, counters 0, and all outputs 0.
- All outputs are registered, with no combinational input-to-output path.
- Cast sampled at edge n:
  - `rnd` is sampled at edge n.
  - `waiting`=1 and `rnd_run`=1 during cycle n+1.
  - `rnd_run` returns to 0 at edge n+1.
- Delay D ≥ 1 with WAIT entered at edge n: BITE is entered at the edge sampling the D-th tick counted after edge n. Ticks coincident with edge n are not counted.
- Outcome event at edge k: pulse is high for cycle k+1 only. `bite`/`waiting` are 0 and `ticks_left` is 0 from edge k.
- A new cast is accepted at edge k+1 or later, giving a one-cycle minimum cast-to-cast gap after an outcome.
- `ticks_left` reflects the counter after the edge, so it decrements one cycle after each counted tick.

## Structure
- Shared package `fishing_pkg`:
  - state enum (IDLE, WAIT, BITE)
  - `RND_W` = 16, the common width for LFSR output and delay
  - default WINDOW_TICKS constant
- One sub-module, `tick_down_counter`:
  - ports: load, load value, tick enable, clear
  - outputs: count, `at_one` flag
  - instantiated once and reused for both WAIT and BITE phases, with the FSM selecting the load value.
- The FSM and outcome pulse registers live in `fish_bite_timer`.

## Test plan
Bench: WINDOW_TICKS=3, tick every 4 clocks.
- Reset: hold RST low 2 cycles with `cast` pulsing → all outputs 0 throughout; `rnd_run` never asserted.
- Catch:
  - Stimulus: `rnd`=5, cast, then reel on the cycle after the 6th counted tick.
  - Response: `rnd_run` one pulse; `waiting` for 5 ticks; `bite` high; `caught` exactly one cycle; `missed`/`spooked` stay 0.
- Miss: `rnd`=2, cast, no reel → `bite` after tick 2; `missed` one cycle after tick 5; back in IDLE.
- Early reel: `rnd`=10, reel after tick 4 → `spooked` one cycle, `ticks_left` 0; a second cast while waiting is ignored.
- Zero/priority:
  - `rnd`=0 → BITE after the first tick.
  - `reel` coincident with the final window tick → `caught`, not `missed`.
  - `cast`+`reel` together in IDLE → WAIT entered.
- Mid-run reset: drop RST during BITE → outputs 0 immediately; no outcome pulse. The next cast after release works normally.

Source files
------------

// File: rtl/fishing_pkg.sv
// Shared fishing-game types and constants: FSM state encoding and the
// common random/delay width used by the LFSR and its consumers.
package fishing_pkg;

  localparam int unsigned RND_W            = 16;
  localparam int unsigned WINDOW_TICKS_DEF = 250;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BITE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter advanced by a time-base enable; floors at 1 and
// flags when it holds 1 so the owner can act on the final tick.
module tick_down_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_one
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count > WIDTH'(1))) begin
      count <= count - WIDTH'(1);
    end
  end

  assign at_one = (count == WIDTH'(1));

endmodule

// File: rtl/fish_bite_timer.sv
// Cast/bite/reel timer: captures an LFSR delay on cast, counts it down on
// ticks, opens a fixed bite window and resolves one outcome pulse per cast.
module fish_bite_timer
  import fishing_pkg::*;
#(
  parameter int unsigned WIDTH        = RND_W,
  parameter int unsigned WINDOW_TICKS = WINDOW_TICKS_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cast,
  input  logic             reel,
  input  logic             tick,
  input  logic [WIDTH-1:0] rnd,
  output logic             rnd_run,
  output logic             waiting,
  output logic             bite,
  output logic             caught,
  output logic             missed,
  output logic             spooked,
  output logic [WIDTH-1:0] ticks_left
);

  state_t           state_q, state_d;
  logic             cnt_clear, cnt_load, cnt_en, cnt_at_one;
  logic [WIDTH-1:0] cnt_load_val;
  logic             run_d, caught_d, missed_d, spooked_d;

  tick_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (ticks_left),
    .at_one   (cnt_at_one)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      rnd_run <= 1'b0;
      caught  <= 1'b0;
      missed  <= 1'b0;
      spooked <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_run <= run_d;
      caught  <= caught_d;
      missed  <= missed_d;
      spooked <= spooked_d;
    end
  end

  // Reel is checked before the final tick in both phases so it always wins.
  always_comb begin
    state_d      = state_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = '0;
    run_d        = 1'b0;
    caught_d     = 1'b0;
    missed_d     = 1'b0;
    spooked_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cast) begin
          state_d      = WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = (rnd == '0) ? WIDTH'(1) : rnd;
          run_d        = 1'b1;
        end
      end
      WAIT: begin
        if (reel) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
          spooked_d = 1'b1;
        end else if (tick && cnt_at_one) begin
          state_d      = BITE;
          cnt_load     = 1'b1;
          cnt_load_val = WIDTH'(WINDOW_TICKS);
        end else begin
          cnt_en = tick;
        end
      end
      BITE: begin
        if (reel) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
          caught_d  = 1'b1;
        end else if (tick && cnt_at_one) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
          missed_d  = 1'b1;
        end else begin
          cnt_en = tick;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  assign waiting = (state_q == WAIT);
  assign bite    = (state_q == BITE);

endmodule
